mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that lets the instruction-fetch path and the load/store path of the RISC-V core share one single-ported memory. Each requester uses a valid/ready request channel and a one-cycle response pulse. The memory side uses a req/ack handshake. A watchdog aborts any memory access that is never acknowledged.

## Interface
Parameters:
- WORD_LENGTH, 32, data width of all data buses
- ADDR_WIDTH, 32, width of all address buses
- TIMEOUT, 16, maximum number of busy cycles without mem_ack before abort; legal range 1..255

Ports:
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- i_valid  input  1  fetch request present
- i_addr  input  ADDR_WIDTH  fetch address
- i_ready  output  1  fetch request accepted this cycle
- i_rvalid  output  1  one-cycle pulse: fetch response valid
- i_rdata  output  WORD_LENGTH  fetched instruction word
- d_valid  input  1  load/store request present
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_WIDTH  load/store address
- d_wdata  input  WORD_LENGTH  store data
- d_ready  output  1  load/store request accepted this cycle
- d_rvalid  output  1  one-cycle pulse: load data valid, or store complete
- d_rdata  output  WORD_LENGTH  load data; 0 for stores
- mem_req  output  1  memory access in progress
- mem_we  output  1  write strobe qualifying mem_req
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  WORD_LENGTH  memory write data
- mem_ack  input  1  memory completion; counted only while mem_req=1
- mem_rdata  input  WORD_LENGTH  read data, valid with mem_ack
- err  output  1  one-cycle pulse when an access is aborted by timeout

## Operation
The block is a finite state machine with three states: IDLE, BUSY, RESP.

IDLE
- i_ready and d_ready are combinational. At most one of them is 1 in any cycle, and only in IDLE.
- Only d_valid: d_ready=1.
- Only i_valid: i_ready=1.
- Both valid: grant goes to the requester that is not last_grant.
- A grant (valid && ready) does the following:
  - Registers the address, data and write strobe onto the mem_* outputs.
  - Records the owner.
  - Updates last_grant.
  - Moves to BUSY.
- For a fetch grant, mem_we=0 and mem_wdata=0.

BUSY
- mem_req=1. The mem_* outputs are held stable.
- Requester valid inputs are ignored.
- The watchdog counts from 0 on every BUSY cycle.
- mem_ack=1: capture mem_rdata into the owner's response register. For a store, capture 0 instead. Go to RESP.
- No mem_ack when the count reaches TIMEOUT-1:
  - Owner response data = 0.
  - Set the abort flag.
  - Go to RESP.

RESP
- mem_req=0.
- The owner's rvalid=1 for exactly this cycle.
- err=1 in this cycle if the abort flag is set.
- Return to IDLE. No new grant is issued in RESP.

Other rules
- i_rdata and d_rdata hold their last value until the next response to that port.
- mem_ack outside BUSY is ignored.
- Requesters must hold valid and payload until ready; the block does not check this.

## Timing
- Grant at cycle 0.
- mem_req=1 from cycle 1.
- mem_ack at cycle k (k≥1) gives rvalid at cycle k+1 and the next possible grant at cycle k+2.
- Zero-wait memory (ack at cycle 1): rvalid at 2, next grant at 3. Throughput is one access per 3 cycles.
- Timeout with TIMEOUT=T: mem_req is high for cycles 1..T; rvalid and err are 1 at cycle T+1.
- When reset goes low, all outputs go to 0 immediately, including mid-access:
  - The state goes to IDLE.
  - last_grant = D, so the first tie after reset goes to fetch.
  - The watchdog count and abort flag clear.
  - No response is issued for an access cut off by reset.
- After reset goes high, the first grant is possible on the first clock edge.
- Arbitration under sustained contention alternates I, D, I, D. Neither requester waits more than one access.

## Structure
- Shared package risc_v_pkg contains:
  - arb_state_t enum: IDLE, BUSY, RESP.
  - Requester-id constants REQ_I=1'b0 and REQ_D=1'b1, used for owner and last_grant.
- One sub-module is natural: arb_timeout_ctr.
  - 8-bit counter with clear and enable inputs.
  - Outputs an expired flag when count == TIMEOUT-1.
  - Uses the same clk and reset.
- The top level holds the FSM, the grant logic, the request capture registers and the response registers.

## Test plan
- Reset, then i_valid=1 with i_addr=0x0000_0004; memory acks in cycle 1 with rdata 0x0010_0093 -> i_ready at cycle 0, mem_addr=0x4 with mem_we=0 at cycle 1, i_rvalid=1 with i_rdata=0x0010_0093 at cycle 2, err=0.
- Store: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF; memory acks after 3 wait cycles -> mem_req high for cycles 1-4, mem_we=1, mem_wdata=0xDEAD_BEEF, d_rvalid at cycle 5, d_rdata=0.
- i_valid and d_valid held high continuously from reset for 4 grants -> grant order I, D, I, D; never two consecutive grants to one port.
- TIMEOUT=4 and memory never acks a load at 0x200 -> mem_req high for cycles 1-4; d_rvalid=1, err=1 and d_rdata=0 at cycle 5; next grant accepted at cycle 6.
- Reset asserted in the second BUSY cycle of a fetch -> mem_req and all outputs drop to 0 at once; no i_rvalid; after release, a tie is granted to fetch first.
- Spurious mem_ack=1 while IDLE -> no rvalid, no state change.

Source files
------------

// File: rtl/risc_v_pkg.sv
// ---------------------------------------------------------------------------
// risc_v_pkg
// Shared types and constants for the memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   REQ_I/REQ_D : requester ids used for the access owner and last grant
// ---------------------------------------------------------------------------
package risc_v_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// ---------------------------------------------------------------------------
// arb_timeout_ctr
// Watchdog counter for a memory access. It counts enabled cycles from 0.
// It flags expiry when the count reaches TIMEOUT-1.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   i_clear   : synchronous clear of the count to 0
//   i_enable  : count this cycle
//   o_expired : count == TIMEOUT-1
// ---------------------------------------------------------------------------
module arb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  logic [7:0] r_count;
  logic       w_expired;

  assign w_expired = (r_count == LAST_COUNT);
  assign o_expired = w_expired;

  // Count register. It holds at the expiry value instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && !w_expired) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported memory between the instruction-fetch (i_*) port
// and the load/store (d_*) port. Each access follows the same sequence:
//   IDLE : grant one request
//   BUSY : wait for mem_ack, or abort when the watchdog expires
//   RESP : pulse the owner's rvalid (plus err on abort), then return to IDLE
// Ports:
//   clk, reset                        clock, async active-low reset
//   i_valid/i_addr/i_ready            fetch request channel
//   i_rvalid/i_rdata                  fetch response
//   d_valid/d_we/d_addr/d_wdata/d_ready  load/store request channel
//   d_rvalid/d_rdata                  load/store response (d_rdata 0 for stores)
//   mem_req/mem_we/mem_addr/mem_wdata memory request, held through BUSY
//   mem_ack/mem_rdata                 memory completion and read data
//   err                               one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module mem_arbiter
  import risc_v_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  output logic                   i_ready,
  output logic                   i_rvalid,
  output logic [WORD_LENGTH-1:0] i_rdata,
  input  logic                   d_valid,
  input  logic                   d_we,
  input  logic [ADDR_WIDTH-1:0]  d_addr,
  input  logic [WORD_LENGTH-1:0] d_wdata,
  output logic                   d_ready,
  output logic                   d_rvalid,
  output logic [WORD_LENGTH-1:0] d_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   err
);

  localparam logic [WORD_LENGTH-1:0] ZERO_WORD = {WORD_LENGTH{1'b0}};

  arb_state_t r_state;
  arb_state_t w_next_state;

  logic                   r_owner;
  logic                   r_last_grant;
  logic                   r_abort;
  logic                   r_mem_we;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [WORD_LENGTH-1:0] r_mem_wdata;
  logic [WORD_LENGTH-1:0] r_i_rdata;
  logic [WORD_LENGTH-1:0] r_d_rdata;

  logic w_grant_i;
  logic w_grant_d;
  logic w_expired;
  logic w_busy;
  logic w_resp;

  assign w_busy = (r_state == BUSY);
  assign w_resp = (r_state == RESP);

  arb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (!w_busy),
    .i_enable  (w_busy),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant selection and next-state logic. On a tie, the grant goes to the
  // requester that did not win last time.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_valid && (!i_valid || (r_last_grant == REQ_I))) begin
          w_grant_d    = 1'b1;
          w_next_state = BUSY;
        end else if (i_valid) begin
          w_grant_i    = 1'b1;
          w_next_state = BUSY;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack || w_expired) begin
          w_next_state = RESP;
        end else begin
          w_next_state = BUSY;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request capture on a grant: the memory request, the owner and the
  // arbitration history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_WIDTH{1'b0}};
      r_mem_wdata  <= ZERO_WORD;
      r_owner      <= REQ_I;
      r_last_grant <= REQ_D;
    end else if (w_grant_d) begin
      r_mem_we     <= d_we;
      r_mem_addr   <= d_addr;
      r_mem_wdata  <= d_wdata;
      r_owner      <= REQ_D;
      r_last_grant <= REQ_D;
    end else if (w_grant_i) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= i_addr;
      r_mem_wdata  <= ZERO_WORD;
      r_owner      <= REQ_I;
      r_last_grant <= REQ_I;
    end else begin
      r_mem_we     <= r_mem_we;
      r_mem_addr   <= r_mem_addr;
      r_mem_wdata  <= r_mem_wdata;
      r_owner      <= r_owner;
      r_last_grant <= r_last_grant;
    end
  end

  // Response capture in BUSY. Ack has priority over a simultaneous expiry.
  // A store or an aborted access returns 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i_rdata <= ZERO_WORD;
      r_d_rdata <= ZERO_WORD;
      r_abort   <= 1'b0;
    end else if (w_busy && mem_ack) begin
      r_abort <= 1'b0;
      if (r_owner == REQ_D) begin
        r_d_rdata <= r_mem_we ? ZERO_WORD : mem_rdata;
        r_i_rdata <= r_i_rdata;
      end else begin
        r_i_rdata <= mem_rdata;
        r_d_rdata <= r_d_rdata;
      end
    end else if (w_busy && w_expired) begin
      r_abort <= 1'b1;
      if (r_owner == REQ_D) begin
        r_d_rdata <= ZERO_WORD;
        r_i_rdata <= r_i_rdata;
      end else begin
        r_i_rdata <= ZERO_WORD;
        r_d_rdata <= r_d_rdata;
      end
    end else if (w_resp) begin
      r_abort   <= r_abort;
      r_i_rdata <= r_i_rdata;
      r_d_rdata <= r_d_rdata;
    end else begin
      r_abort   <= 1'b0;
      r_i_rdata <= r_i_rdata;
      r_d_rdata <= r_d_rdata;
    end
  end

  // The ready outputs are gated by reset so that every output drops as soon
  // as reset is asserted, even while a requester keeps valid high.
  assign i_ready   = reset & w_grant_i;
  assign d_ready   = reset & w_grant_d;

  assign mem_req   = w_busy;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  assign i_rvalid  = w_resp & (r_owner == REQ_I);
  assign d_rvalid  = w_resp & (r_owner == REQ_D);
  assign err       = w_resp & r_abort;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with TIMEOUT=4. Each cycle starts 1 time
// unit after a rising edge. Inputs are driven at that point. Outputs are
// checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_valid;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(
    .WORD_LENGTH (32),
    .ADDR_WIDTH  (32),
    .TIMEOUT     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_valid   (d_valid),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    i_valid   = 1'b0;
    i_addr    = 32'h0;
    d_valid   = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
    chk("rst_mem_addr", mem_addr,          32'd0);
    chk("rst_rvalid",   {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);

    // Fetch with zero-wait memory.
    tick();
    reset = 1'b1; i_valid = 1'b1; i_addr = 32'h0000_0004;
    settle();
    chk("f_i_ready_c0", {31'd0, i_ready}, 32'd1);
    chk("f_d_ready_c0", {31'd0, d_ready}, 32'd0);
    tick();
    i_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0010_0093;
    settle();
    chk("f_mem_req_c1",  {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr_c1", mem_addr,         32'h4);
    chk("f_mem_we_c1",   {31'd0, mem_we},  32'd0);
    chk("f_rvalid_c1",   {31'd0, i_rvalid}, 32'd0);
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    settle();
    chk("f_i_rvalid_c2", {31'd0, i_rvalid}, 32'd1);
    chk("f_i_rdata_c2",  i_rdata,           32'h0010_0093);
    chk("f_err_c2",      {31'd0, err},      32'd0);
    chk("f_mem_req_c2",  {31'd0, mem_req},  32'd0);
    tick();
    chk("f_i_rvalid_c3", {31'd0, i_rvalid}, 32'd0);
    chk("f_i_rdata_hold", i_rdata,          32'h0010_0093);

    // Load with zero-wait memory, so d_rdata is non-zero before the store.
    d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    settle();
    chk("l_d_ready", {31'd0, d_ready}, 32'd1);
    tick();
    d_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    settle();
    chk("l_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("l_d_rdata",  d_rdata,           32'h1234_5678);
    tick();

    // Store acknowledged after three wait cycles. Fetch requests made
    // during BUSY must not be granted.
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    settle();
    chk("s_d_ready_c0", {31'd0, d_ready}, 32'd1);
    tick();
    d_valid = 1'b0; i_valid = 1'b1; i_addr = 32'h8;
    settle();
    chk("s_i_ready_busy", {31'd0, i_ready}, 32'd0);
    i_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      end
      settle();
      chk("s_mem_req",   {31'd0, mem_req}, 32'd1);
      chk("s_mem_we",    {31'd0, mem_we},  32'd1);
      chk("s_mem_wdata", mem_wdata,        32'hDEAD_BEEF);
      chk("s_mem_addr",  mem_addr,         32'h100);
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    settle();
    chk("s_d_rvalid_c5", {31'd0, d_rvalid}, 32'd1);
    chk("s_d_rdata_c5",  d_rdata,           32'd0);
    chk("s_mem_req_c5",  {31'd0, mem_req},  32'd0);
    tick();

    // Contention from reset: both requesters held valid, zero-wait memory.
    // Expected grant order is I, D, I, D.
    reset = 1'b0;
    settle();
    tick();
    reset = 1'b1; i_valid = 1'b1; i_addr = 32'h40;
    d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int g = 0; g < 4; g++) begin
      settle();
      chk("c_i_ready", {31'd0, i_ready}, (g % 2 == 0) ? 32'd1 : 32'd0);
      chk("c_d_ready", {31'd0, d_ready}, (g % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("c_mem_addr", mem_addr, (g % 2 == 0) ? 32'h40 : 32'h80);
      chk("c_busy_ready", {30'd0, i_ready, d_ready}, 32'd0);
      tick();
      chk("c_i_rvalid", {31'd0, i_rvalid}, (g % 2 == 0) ? 32'd1 : 32'd0);
      chk("c_d_rvalid", {31'd0, d_rvalid}, (g % 2 == 0) ? 32'd0 : 32'd1);
      chk("c_resp_ready", {30'd0, i_ready, d_ready}, 32'd0);
      tick();
    end
    i_valid = 1'b0; d_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    settle();
    chk("c_d_rdata", d_rdata, 32'hCAFE_F00D);
    tick();

    // Timeout: load at 0x200 that is never acknowledged.
    d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    settle();
    chk("t_d_ready_c0", {31'd0, d_ready}, 32'd1);
    tick();
    d_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk("t_mem_req", {31'd0, mem_req}, 32'd1);
      chk("t_err_busy", {31'd0, err},    32'd0);
      tick();
    end
    settle();
    chk("t_mem_req_c5",  {31'd0, mem_req},  32'd0);
    chk("t_d_rvalid_c5", {31'd0, d_rvalid}, 32'd1);
    chk("t_err_c5",      {31'd0, err},      32'd1);
    chk("t_d_rdata_c5",  d_rdata,           32'd0);
    tick();
    i_valid = 1'b1; i_addr = 32'hC;
    settle();
    chk("t_i_ready_c6", {31'd0, i_ready}, 32'd1);
    chk("t_err_c6",     {31'd0, err},     32'd0);
    tick();
    i_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ack = 1'b0;
    settle();
    chk("t_follow_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("t_follow_err",    {31'd0, err},      32'd0);
    tick();

    // Reset in the second BUSY cycle of a fetch.
    i_valid = 1'b1; i_addr = 32'h0000_0020;
    settle();
    chk("r_i_ready_c0", {31'd0, i_ready}, 32'd1);
    tick();
    i_valid = 1'b0;
    tick();
    settle();
    chk("r_mem_req_c2", {31'd0, mem_req}, 32'd1);
    reset = 1'b0; i_valid = 1'b1; d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h44;
    settle();
    chk("r_mem_req_drop",  {31'd0, mem_req}, 32'd0);
    chk("r_mem_addr_drop", mem_addr,         32'd0);
    chk("r_i_rdata_drop",  i_rdata,          32'd0);
    chk("r_ready_drop",    {30'd0, i_ready, d_ready}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("r_no_rvalid", {29'd0, i_rvalid, d_rvalid, err}, 32'd0);
    end
    reset = 1'b1;
    settle();
    chk("r_tie_i_ready", {31'd0, i_ready}, 32'd1);
    chk("r_tie_d_ready", {31'd0, d_ready}, 32'd0);
    tick();
    i_valid = 1'b0; d_valid = 1'b0;
    settle();
    chk("r_after_addr", mem_addr, 32'h20);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_ack = 1'b0;
    tick();

    // Spurious ack while IDLE.
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("sp_idle", {28'd0, mem_req, i_rvalid, d_rvalid, err}, 32'd0);
      tick();
    end
    chk("sp_i_rdata", i_rdata, 32'd0);
    mem_ack = 1'b0;
    i_valid = 1'b1; i_addr = 32'h30;
    settle();
    chk("sp_i_ready", {31'd0, i_ready}, 32'd1);
    tick();
    i_valid = 1'b0;
    settle();
    chk("sp_mem_req", {31'd0, mem_req}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
